// File: rtl/audio_capture_fifo.sv
// audio_capture_fifo: packs 20-bit left-justified samples into 32-bit words per mode, 8-deep word FIFO to host.
// Build option AUDIO_CAP_FLUSH_EN adds a flush input that writes out a pending 16-bit half word.
module audio_capture_fifo #(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [19:0] din,
  input  logic        we,
  input  logic        re,
`ifdef AUDIO_CAP_FLUSH_EN
  input  logic        flush,
`endif
  output logic [31:0] dout,
  output logic [1:0]  status,
  output logic        full,
  output logic        empty,
  output logic        overrun
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HI_CNT   = (AW+1)'((3 * DEPTH) / 4);
  localparam logic [AW:0] MID_CNT  = (AW+1)'(DEPTH / 2);

  typedef enum logic {IDLE, HALF} state_t;

  state_t        state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic [1:0]    mode_q;
  logic          word_vld;
  logic [31:0]   word_dat;
  logic          do_flush;
  logic          wr_ok, rd_ok;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

`ifdef AUDIO_CAP_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Mode-change discard happens first, then the sample, then flush, so at most one word forms per cycle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    word_vld = 1'b0;
    word_dat = '0;
    if (en) begin
      if (state_q == HALF && mode != mode_q) begin
        state_d = IDLE;
        hold_d  = '0;
      end
      if (we) begin
        case (mode)
          2'd0: begin
            if (state_d == HALF) begin
              word_vld = 1'b1;
              word_dat = {din[19:4], hold_q};
              state_d  = IDLE;
            end else begin
              hold_d  = din[19:4];
              state_d = HALF;
            end
          end
          2'd1: begin
            word_vld = 1'b1;
            word_dat = {14'h0, din[19:2]};
          end
          2'd2: begin
            word_vld = 1'b1;
            word_dat = {12'h0, din};
          end
          default: ;
        endcase
      end
      if (do_flush && state_d == HALF) begin
        word_vld = 1'b1;
        word_dat = {16'h0, hold_d};
        state_d  = IDLE;
      end
    end
  end

  // Fullness is judged on the pre-edge count, so a write into a full FIFO drops even alongside a read.
  assign wr_ok = word_vld && (cnt != FULL_CNT);
  assign rd_ok = en && re && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mode_q  <= '0;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      dout    <= '0;
      overrun <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mode_q  <= mode;
      if (wr_ok) wp <= wp + 1'b1;
      if (word_vld && !wr_ok) overrun <= 1'b1;
      if (rd_ok) begin
        dout <= mem[rp];
        rp   <= rp + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wp] <= word_dat;
  end

  always_comb begin
    if (cnt == FULL_CNT)    status = 2'b11;
    else if (cnt >= HI_CNT) status = 2'b10;
    else if (cnt >= MID_CNT) status = 2'b01;
    else                    status = 2'b00;
  end

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

endmodule

// File: tb/tb_audio_capture_fifo.sv
// Bench for audio_capture_fifo: directed literal checks plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_audio_capture_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [19:0] din = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] dout;
  logic [1:0]  status;
  logic        full, empty, overrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  audio_capture_fifo #(.AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .din(din),
    .we(we),
    .re(re),
`ifdef AUDIO_CAP_FLUSH_EN
    .flush(flush),
`endif
    .dout(dout),
    .status(status),
    .full(full),
    .empty(empty),
    .overrun(overrun)
  );

  // Reference model: a word queue, an optional pending half word, last mode, sticky overrun, last read word.
  logic [31:0] mq[$];
  bit          m_half = 1'b0;
  logic [15:0] m_hold = '0;
  logic [1:0]  m_pmode = '0;
  bit          m_ovr = 1'b0;
  logic [31:0] m_dout = '0;

  always @(posedge clk) begin
    int          n0;
    bit          wv;
    logic [31:0] w;
    if (rst) begin
      mq.delete();
      m_half = 0; m_hold = '0; m_pmode = '0; m_ovr = 0; m_dout = '0;
    end else if (en) begin
      n0 = mq.size();
      wv = 0;
      w  = '0;
      if (m_half && mode != m_pmode) m_half = 0;
      if (we) begin
        if (mode == 2'd0) begin
          if (m_half) begin w = {din[19:4], m_hold}; wv = 1; m_half = 0; end
          else begin m_hold = din[19:4]; m_half = 1; end
        end else if (mode == 2'd1) begin
          w = din >> 2; wv = 1;
        end else if (mode == 2'd2) begin
          w = din; wv = 1;
        end
      end
`ifdef AUDIO_CAP_FLUSH_EN
      if (flush && m_half) begin w = m_hold; wv = 1; m_half = 0; end
`endif
      m_pmode = mode;
      if (re && n0 > 0) m_dout = mq.pop_front();
      if (wv) begin
        if (n0 < 8) mq.push_back(w);
        else m_ovr = 1;
      end
    end
  end

  function automatic logic [1:0] band(int n);
    if (n == 8) return 2'b11;
    if (n >= 6) return 2'b10;
    if (n >= 4) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_dout",    dout,           m_dout);
      chk("m_full",    32'(full),      32'(mq.size() == 8));
      chk("m_empty",   32'(empty),     32'(mq.size() == 0));
      chk("m_status",  32'(status),    32'(band(mq.size())));
      chk("m_overrun", 32'(overrun),   32'(m_ovr));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick; tick;
    chk_on = 1'b1;
    rst = 1'b0; en = 1'b1;
    tick;
    chk("rst_dout", dout, 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    mode = 2'd0; we = 1; din = 20'hABCD0; tick;
    din = 20'h12340; tick;
    we = 0; re = 1; tick;
    re = 0;
    chk("pair_dout", dout, 32'h1234ABCD);
    chk("pair_empty", 32'(empty), 32'd1);

    mode = 2'd2; we = 1;
    for (int i = 1; i <= 9; i++) begin din = 20'(i); tick; end
    we = 0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_status", 32'(status), 32'd3);
    chk("fill_overrun", 32'(overrun), 32'd1);

    we = 1; re = 1; din = 20'h0000A; tick;
    we = 0; re = 0;
    chk("rw_full_dout", dout, 32'h1);
    chk("rw_full_status", 32'(status), 32'd2);
    chk("rw_full_nfull", 32'(full), 32'd0);
    chk("rw_full_overrun", 32'(overrun), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      re = 1; tick;
      chk("drain_dout", dout, 32'(i));
    end
    re = 0;
    chk("drain_empty", 32'(empty), 32'd1);

    mode = 2'd0; we = 1; din = 20'hFFFF0; tick;
    mode = 2'd1; din = 20'h00004; tick;
    we = 0; re = 1; tick;
    chk("modechg_dout", dout, 32'h1);
    chk("modechg_empty", 32'(empty), 32'd1);
    tick;
    re = 0;
    chk("re_empty_hold", dout, 32'h1);

`ifdef AUDIO_CAP_FLUSH_EN
    mode = 2'd0; we = 1; din = 20'h55550; tick;
    we = 0; flush = 1; tick;
    flush = 0; re = 1; tick;
    re = 0;
    chk("flush_dout", dout, 32'h00005555);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 96) == 0);
      en  = ($urandom_range(0, 7) != 0);
      we  = ($urandom_range(0, 2) != 0);
      re  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 9) == 0);
      din = 20'($urandom);
      tick;
    end
    rst = 0; en = 0; we = 0; re = 0; flush = 0;
    tick;
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_capture_fifo.md
# audio_capture_fifo

Capture-side counterpart of the playback audio FIFO. Accepts 20-bit left-justified audio samples from the codec/ADC interface and packs them per `mode` into 32-bit words. The packing matches the playback FIFO's unpacking, so a buffer read here replays unchanged through playback. Words are buffered in an 8-deep FIFO and drained by the host/bus side one word per read strobe.

## Interface
Parameters:
- `AW`, 3, FIFO address width; depth = 2^AW words (8).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  global enable; when 0 all state holds and `we`/`re` are ignored.
- `mode`  in  2  packing: 0 = 16-bit pairs, 1 = 18-bit, 2 = 20-bit, 3 = reserved.
- `din`  in  20  sample, left-justified (MSB at bit 19).
- `we`  in  1  sample valid, one sample per asserted cycle.
- `re`  in  1  host read strobe.
- `dout`  out  32  registered read word.
- `status`  out  2  fill level band.
- `full`  out  1  count == 2^AW.
- `empty`  out  1  count == 0.
- `overrun`  out  1  sticky: a packed word was dropped because the FIFO was full.

## Operation
- Storage: 2^AW x 32 array, write pointer `wp` and read pointer `rp` (AW bits each, natural wrap), and a count register `cnt` (AW+1 bits, 0..2^AW).
- Packer FSM has two states:
  - IDLE: no pending half word.
  - HALF: holds a 16-bit low half in `hold`.
- Word formation on `en && we`:
  - mode 0, IDLE: `hold <= din[19:4]`, go to HALF; nothing is written to the FIFO.
  - mode 0, HALF: word = {din[19:4], hold}, go to IDLE.
  - mode 1: word = {14'h0, din[19:2]}.
  - mode 2: word = {12'h0, din}.
  - mode 3: sample discarded, no state change.
- FIFO write: a formed word is stored at `wp` and `wp` increments if `cnt` < 2^AW before the edge. Otherwise the word is dropped and `overrun` is set to 1. `overrun` clears only on `rst`.
- A dropped word still advances the FSM to IDLE, so pairing stays aligned.
- Mode change: a registered copy of `mode` is kept. If `mode` differs from it while in HALF, `hold` is discarded and the FSM returns to IDLE. The sample presented in that cycle is then processed under the new mode from IDLE.
- Read: on `en && re && !empty`, `dout <= mem[rp]` and `rp` increments. `re` while empty leaves `dout` and `rp` unchanged.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Status bands: 00 for `cnt` 0–3, 01 for 4–5, 10 for 6–7, 11 for 8.

## Timing
- Reset values: `dout` = 0, `status` = 00, `full` = 0, `empty` = 1, `overrun` = 0. Reset also sets `wp` = `rp` = `cnt` = 0, FSM to IDLE, `hold` = 0, and the registered mode to 0.
- `rst` has priority over `en`.
- Sample-to-FIFO latency: a word written at edge N is readable by `re` in cycle N+1.
- Read latency: `dout` is valid the cycle after the `re` edge and holds until the next accepted read.
- `full`, `empty`, and `status` are decoded from `cnt` and update on the same edge as `cnt`.
- Simultaneous read and write:
  - When `full`: the read is accepted and the write is dropped (fullness is evaluated before the edge), setting `overrun`; `cnt` becomes 7.
  - When `empty`: the read is ignored and the write is stored; `cnt` becomes 1.

## Configuration
- `AUDIO_CAP_FLUSH_EN` defined: adds input port `flush` (1 bit).
  - On `en && flush` in HALF, {16'h0, `hold`} is written (same full/overrun rules) and the FSM returns to IDLE.
  - `flush` in IDLE has no effect.
  - If `we` and `flush` are both asserted, `we` is processed first and `flush` applies only if the FSM is still in HALF after it.
- Not defined: no `flush` port; a half word is only completed by a second sample or discarded by a mode change.

## Test plan
- Reset, then idle: `dout` = 0, `empty` = 1, `full` = 0, `status` = 00, `overrun` = 0.
- mode 0, samples 20'hABCD0 then 20'h12340, then `re`: next cycle `dout` = 32'h1234ABCD, `empty` = 1.
- mode 2, nine samples 20'h00001..20'h00009 with no reads: `full` = 1, `status` = 11, `overrun` = 1. Then eight reads return 32'h00001..32'h00008 in order.
- mode 0, one sample 20'hFFFF0, then switch to mode 1 with sample 20'h00004: exactly one word, 32'h00000001, is stored.
- FIFO full, then `we` (mode 2) and `re` in the same cycle: read returns the oldest word, `cnt` = 7, `overrun` = 1.
- With `AUDIO_CAP_FLUSH_EN`: mode 0, sample 20'h55550, then `flush`, then `re`: `dout` = 32'h00005555.
